serializador: RTL and testbench
===============================

Name: serializador

Overview:
Upstream companion to the deserializer. Accepts parallel words through a valid/ready handshake and shifts each one out MSB-first as the single-bit data stream plus write-strobe that the deserializer consumes. It has a one-word holding register, so the next word can be accepted while the current word is shifting. It respects a back-pressure input driven by the deserializer's status output. It runs in the 100 kHz domain.

Parameters:
- WIDTH, 8, bits per word shifted out
- GAP_CYCLES, 1, idle cycles with write_out=0 inserted after each word (0 allowed = back-to-back words)

Ports:
- clk_100KHz  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset asserted)
- data_in  input  WIDTH  parallel word to transmit
- valid_in  input  1  data_in is valid this cycle
- ready_out  output  1  holding register empty; a word is accepted when valid_in && ready_out at a clock edge
- stall_in  input  1  downstream busy; blocks the start of a new word only
- data_out  output  1  serial bit, registered
- write_out  output  1  high while data_out carries a valid bit, registered
- busy_out  output  1  state != IDLE or holding register occupied
- words_sent  output  8  count of completed words, wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hold_valid=0, shift register=0, bit counter=0, data_out=0, write_out=0, words_sent=0, busy_out=0, ready_out=1.
  - Reset mid-word discards both the partial word and any held word. No further bits are emitted.
- ready_out = !hold_valid (combinational from the registered flag).
- Accept: at an edge with valid_in && ready_out, hold <= data_in and hold_valid <= 1.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If hold_valid && !stall_in: shift <= hold, hold_valid <= 0, bit counter <= 0, go to SHIFT.
  - On that same edge, data_out <= hold[WIDTH-1] and write_out <= 1.
  - Otherwise write_out <= 0 and data_out holds its value.
- SHIFT:
  - Each edge presents the next bit, MSB first.
  - After the bit at index 0 has been presented for one cycle: write_out <= 0 and words_sent increments.
  - Next state is GAP if GAP_CYCLES > 0, else IDLE.
  - With GAP_CYCLES=0 and hold_valid && !stall_in, the next word starts on that same edge. write_out stays 1 with no bubble.
  - stall_in is ignored while in SHIFT; a word once started always completes.
- GAP: write_out=0 for exactly GAP_CYCLES cycles, then IDLE.
- Latency: word accepted at edge k, no stall:
  - write_out=1 for edges k+1..k+WIDTH.
  - MSB appears at k+1.
  - write_out falls and words_sent increments at k+WIDTH+1.
- A new word may be accepted while shifting; the holding register frees at the edge the word moves into the shift register.
- valid_in while ready_out=0: the word is not accepted. The source must hold data_in/valid_in stable until accepted.
- stall_in high in IDLE with a held word: the word waits indefinitely, ready_out=0, busy_out=1. It starts on the first edge with stall_in=0.

Optional Feature:
- PARITY_EN:
  - When defined, an even-parity bit (XOR of all WIDTH bits) is shifted out after bit 0, as one extra cycle with write_out=1.
  - A word then occupies WIDTH+1 write_out cycles. words_sent increments after the parity bit.
- When not defined, exactly WIDTH bits are sent and no parity logic exists.

Test Plan:
- Reset, then data_in=8'hA5 with a 1-cycle valid_in -> write_out high 8 cycles, data_out sequence 1,0,1,0,0,1,0,1; words_sent=1; ready_out=1 after.
- Two words 8'hFF then 8'h00 presented back-to-back, GAP_CYCLES=1 -> second accepted during first word's shift; serial stream 11111111, one cycle write_out=0, 00000000; words_sent=2.
- stall_in=1, send 8'h3C -> no write_out, ready_out=0, busy_out=1 for 20 cycles; release stall_in -> 00111100 emitted starting next edge.
- Assert reset=0 after 4 bits of 8'hC3 -> write_out=0 immediately; words_sent=0; after release no residual bits.
- 256 words of 8'h01 -> words_sent wraps to 0; no lost or extra write_out cycles (total 2048 high cycles).
- PARITY_EN defined, send 8'h07 -> 9 write_out cycles, last bit 1; send 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serializador.sv
// serializador: accepts parallel words on a valid/ready handshake and shifts them out MSB-first with a write strobe.
// Optional build macro PARITY_EN appends an even-parity bit after bit 0 of every word.
module serializador #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk_100KHz,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic             stall_in,
   output logic             data_out,
   output logic             write_out,
   output logic             busy_out,
   output logic [7:0]       words_sent
);

`ifdef PARITY_EN
   localparam int LAST_IDX = WIDTH;
`else
   localparam int LAST_IDX = WIDTH - 1;
`endif
   localparam int CNT_W    = $clog2(WIDTH + 2);
   localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] hold_q;
   logic             hold_vld_q;
   logic             hold_vld_d;
   logic [WIDTH-2:0] shift_q;
   logic [CNT_W-1:0] bitcnt_q;
   logic [GAP_W-1:0] gapcnt_q;
   logic             data_out_q;
   logic             write_q;
   logic [7:0]       words_q;
   logic             accept;
   logic             word_done;
   logic             gap_done;
   logic             launch;
   logic             next_bit;
`ifdef PARITY_EN
   logic             par_q;
`endif

   assign ready_out  = !hold_vld_q;
   assign busy_out   = (state_q != IDLE) || hold_vld_q;
   assign data_out   = data_out_q;
   assign write_out  = write_q;
   assign words_sent = words_q;

   assign accept    = valid_in && ready_out;
   assign word_done = (state_q == SHIFT) && (bitcnt_q == CNT_W'(LAST_IDX));
   assign gap_done  = (state_q == GAP) && (gapcnt_q == GAP_W'(GAP_LAST));
   // A word may start from IDLE, on the final gap cycle, or right after the last bit when there is no gap.
   assign launch    = hold_vld_q && !stall_in &&
                      ((state_q == IDLE) || gap_done || (word_done && (GAP_CYCLES == 0)));
   assign hold_vld_d = accept ? 1'b1 : (launch ? 1'b0 : hold_vld_q);

`ifdef PARITY_EN
   assign next_bit = (bitcnt_q == CNT_W'(WIDTH - 1)) ? par_q : shift_q[WIDTH-2];
`else
   assign next_bit = shift_q[WIDTH-2];
`endif

   always_ff @(posedge clk_100KHz or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         shift_q    <= '0;
         bitcnt_q   <= '0;
         gapcnt_q   <= '0;
         data_out_q <= 1'b0;
         write_q    <= 1'b0;
         words_q    <= '0;
`ifdef PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         if (accept) begin
            hold_q <= data_in;
         end
         hold_vld_q <= hold_vld_d;
         if (word_done) begin
            words_q <= words_q + 8'd1;
         end
         if (launch) begin
            // MSB goes straight to the output; the shifter keeps only the bits still to come.
            shift_q    <= hold_q[WIDTH-2:0];
            data_out_q <= hold_q[WIDTH-1];
            write_q    <= 1'b1;
            bitcnt_q   <= '0;
            state_q    <= SHIFT;
`ifdef PARITY_EN
            par_q      <= ^hold_q;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  write_q <= 1'b0;
               end
               SHIFT: begin
                  if (word_done) begin
                     write_q  <= 1'b0;
                     gapcnt_q <= '0;
                     state_q  <= (GAP_CYCLES > 0) ? GAP : IDLE;
                  end else begin
                     data_out_q <= next_bit;
                     shift_q    <= shift_q << 1;
                     bitcnt_q   <= bitcnt_q + CNT_W'(1);
                  end
               end
               GAP: begin
                  write_q <= 1'b0;
                  if (gap_done) begin
                     state_q <= IDLE;
                  end else begin
                     gapcnt_q <= gapcnt_q + GAP_W'(1);
                  end
               end
               default: begin
                  write_q <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serializador.sv
// Testbench for serializador: directed vector table, multi-cycle corner cases and a randomized scoreboard run.
module tb_serializador;

   localparam int W   = 8;
   localparam int GAP = 1;
`ifdef PARITY_EN
   localparam int BITS = W + 1;
`else
   localparam int BITS = W;
`endif

   logic         clk;
   logic         rst_n;
   logic [W-1:0] data_in;
   logic         valid_in;
   logic         ready_out;
   logic         stall_in;
   logic         data_out;
   logic         write_out;
   logic         busy_out;
   logic [7:0]   words_sent;

   int n_checks = 0;
   int n_err    = 0;
   int exp_words = 0;

   // scoreboard state
   bit mon_en = 1'b0;
   bit exp_q[$];
   int mon_bit = 0;
   int zero_run = 0;
   bit seen_word = 1'b0;
   int high_cnt = 0;

   serializador #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
      .clk_100KHz (clk),
      .reset      (rst_n),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .stall_in   (stall_in),
      .data_out   (data_out),
      .write_out  (write_out),
      .busy_out   (busy_out),
      .words_sent (words_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serial bit i of a word: data bits MSB first, then even parity.
   function automatic bit wbit(input logic [7:0] w, input int i);
      if (i < W) return w[W-1-i];
      return ^w;
   endfunction

   function automatic void push_word(input logic [7:0] w);
      for (int i = 0; i < BITS; i++) exp_q.push_back(wbit(w, i));
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (write_out === 1'b1) begin
            high_cnt++;
            if (mon_bit == 0 && seen_word && zero_run < GAP)
               chk("gap_len", zero_run, GAP);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL extra_bit: write_out high with nothing expected");
            end else begin
               chk("stream_bit", data_out, exp_q.pop_front());
            end
            mon_bit++;
            if (mon_bit == BITS) begin
               mon_bit = 0;
               exp_words++;
               seen_word = 1'b1;
            end
            zero_run = 0;
         end else begin
            if (mon_bit != 0) chk("bubble_in_word", mon_bit, 0);
            zero_run++;
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      while (busy_out !== 1'b0 && g < 50) begin
         tick();
         g++;
      end
      if (g >= 50) fail_bound("wait_idle");
   endtask

   // Called when the next edge is the one that launches the word.
   task automatic expect_word(input string name, input logic [7:0] seq, input bit par);
      bit b;
      for (int i = 0; i < BITS; i++) begin
         tick();
         b = (i < W) ? seq[W-1-i] : par;
         chk({name, "_write"}, write_out, 1'b1);
         chk({name, "_data"}, data_out, b);
      end
      tick();
      chk({name, "_write_fall"}, write_out, 1'b0);
      exp_words++;
      chk({name, "_words"}, words_sent, exp_words[7:0]);
      chk({name, "_ready"}, ready_out, 1'b1);
   endtask

   task automatic stream(input int n, input bit rnd);
      logic [7:0] w;
      bit acc;
      int g;
      for (int i = 0; i < n; i++) begin
         w = rnd ? 8'($urandom) : 8'h01;
         data_in  = w;
         valid_in = 1'b1;
         acc = 1'b0;
         g = 0;
         while (!acc && g < 200) begin
            acc = (ready_out === 1'b1);
            if (rnd) stall_in = ($urandom_range(0, 3) == 0);
            tick();
            g++;
         end
         if (!acc) fail_bound("accept");
         else push_word(w);
         valid_in = 1'b0;
         if (rnd) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
               stall_in = ($urandom_range(0, 3) == 0);
               tick();
            end
         end
      end
      stall_in = 1'b0;
      g = 0;
      while ((exp_q.size() != 0 || busy_out === 1'b1) && g < 500) begin
         tick();
         g++;
      end
      if (g >= 500) fail_bound("drain");
      tick();
      chk("queue_empty", exp_q.size(), 0);
      chk("stream_words", words_sent, exp_words[7:0]);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [7:0] seq;
      bit         par;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int acc_at;
      int hi;
      bit acc;
      bit ew, ed;

      vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
      vecs[1] = '{8'h3C, 8'b00111100, 1'b0};
      vecs[2] = '{8'hFF, 8'b11111111, 1'b0};
      vecs[3] = '{8'h00, 8'b00000000, 1'b0};
      vecs[4] = '{8'h81, 8'b10000001, 1'b0};
      vecs[5] = '{8'h07, 8'b00000111, 1'b1};
      vecs[6] = '{8'h03, 8'b00000011, 1'b0};
      vecs[7] = '{8'h80, 8'b10000000, 1'b1};
      vecs[8] = '{8'h5A, 8'b01011010, 1'b0};

      rst_n = 1'b0;
      data_in = '0;
      valid_in = 1'b0;
      stall_in = 1'b0;
      tick(); tick(); tick();
      chk("rst_write", write_out, 1'b0);
      chk("rst_data", data_out, 1'b0);
      chk("rst_words", words_sent, 8'd0);
      chk("rst_busy", busy_out, 1'b0);
      chk("rst_ready", ready_out, 1'b1);
      rst_n = 1'b1;
      tick();

      // Directed single-word vectors.
      for (int v = 0; v < 9; v++) begin
         wait_idle();
         data_in = vecs[v].data;
         valid_in = 1'b1;
         tick();
         valid_in = 1'b0;
         chk("vec_hold_full", ready_out, 1'b0);
         chk("vec_busy", busy_out, 1'b1);
         expect_word("vec", vecs[v].seq, vecs[v].par);
      end

      // Back-to-back FF then 00: second word accepted while the first shifts.
      wait_idle();
      data_in = 8'hFF;
      valid_in = 1'b1;
      tick();
      data_in = 8'h00;
      acc_at = -1;
      for (int c = 1; c <= 2 * BITS + GAP + 1; c++) begin
         acc = (ready_out === 1'b1) && valid_in;
         tick();
         if (acc) begin
            valid_in = 1'b0;
            acc_at = c;
         end
         ed = 1'b0;
         if (c <= BITS) begin
            ew = 1'b1; ed = wbit(8'hFF, c - 1);
         end else if (c <= BITS + GAP) begin
            ew = 1'b0;
         end else if (c <= 2 * BITS + GAP) begin
            ew = 1'b1; ed = wbit(8'h00, c - BITS - GAP - 1);
         end else begin
            ew = 1'b0;
         end
         chk("b2b_write", write_out, ew);
         if (ew) chk("b2b_data", data_out, ed);
      end
      chk("b2b_accept_edge", acc_at, 2);
      exp_words += 2;
      chk("b2b_words", words_sent, exp_words[7:0]);

      // Stall holds a word in the holding register.
      wait_idle();
      stall_in = 1'b1;
      data_in = 8'h3C;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("stall_wrb", {write_out, ready_out, busy_out}, 3'b001);
      end
      stall_in = 1'b0;
      expect_word("stall", 8'b00111100, 1'b0);

      // Reset mid-word.
      wait_idle();
      data_in = 8'hC3;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("mid_pre_write", write_out, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", {write_out, data_out, ready_out, busy_out}, 4'b0010);
      chk("mid_rst_words", words_sent, 8'd0);
      tick(); tick();
      rst_n = 1'b1;
      exp_words = 0;
      hi = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (write_out !== 1'b0) hi++;
      end
      chk("mid_residual", hi, 0);
      chk("mid_busy", busy_out, 1'b0);

      // 256 words of 01: words_sent wraps, exact number of strobe cycles.
      exp_q.delete();
      mon_bit = 0;
      zero_run = 0;
      seen_word = 1'b0;
      high_cnt = 0;
      mon_en = 1'b1;
      stream(256, 1'b0);
      chk("wrap_words", words_sent, 8'd0);
      chk("wrap_high_cycles", high_cnt, 256 * BITS);

      // Randomized words, gaps and stall against the scoreboard.
      stream(300, 1'b1);
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
